// File: rtl/dmac_transfer_engine.sv
// DMAC transfer engine: latches a descriptor from the register file, then copies
// SIZE bytes over the system bus one byte at a time (read, then write).
module dmac_transfer_engine #(
    parameter logic [2:0] REG_OP   = 3'd0,
    parameter logic [2:0] REG_CTRL = 3'd1,
    parameter logic [2:0] REG_SRC  = 3'd2,
    parameter logic [2:0] REG_DST  = 3'd3,
    parameter logic [2:0] REG_SIZE = 3'd4
) (
    input  logic       clk,
    input  logic       reset,
    output logic [2:0] rAddr,
    input  logic [7:0] rData,
    output logic       m_req,
    input  logic       m_grant,
    output logic       m_wr,
    output logic [7:0] m_addr,
    output logic [7:0] m_dout,
    input  logic [7:0] m_din,
    output logic       busy,
    output logic       op_done,
    output logic       interrupt
);

    typedef enum logic [3:0] {
        IDLE,
        LOAD_CTRL,
        LOAD_SRC,
        LOAD_DST,
        LOAD_SIZE,
        REQ,
        READ,
        WRITE,
        DONE
    } state_t;

    state_t     state_reg, state_next;
    logic [7:0] src_reg, src_next;
    logic [7:0] dst_reg, dst_next;
    logic [7:0] cnt_reg, cnt_next;
    logic [7:0] data_reg, data_next;
    logic       int_en_reg, int_en_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            src_reg    <= 8'd0;
            dst_reg    <= 8'd0;
            cnt_reg    <= 8'd0;
            data_reg   <= 8'd0;
            int_en_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            src_reg    <= src_next;
            dst_reg    <= dst_next;
            cnt_reg    <= cnt_next;
            data_reg   <= data_next;
            int_en_reg <= int_en_next;
        end
    end

    // Next-state and descriptor/datapath updates
    always_comb begin
        state_next  = state_reg;
        src_next    = src_reg;
        dst_next    = dst_reg;
        cnt_next    = cnt_reg;
        data_next   = data_reg;
        int_en_next = int_en_reg;
        case (state_reg)
            IDLE: begin
                if (rData[0]) state_next = LOAD_CTRL;
            end
            LOAD_CTRL: begin
                int_en_next = rData[0];
                state_next  = LOAD_SRC;
            end
            LOAD_SRC: begin
                src_next   = rData;
                state_next = LOAD_DST;
            end
            LOAD_DST: begin
                dst_next   = rData;
                state_next = LOAD_SIZE;
            end
            LOAD_SIZE: begin
                cnt_next   = rData;
                state_next = (rData == 8'd0) ? DONE : REQ;
            end
            REQ: begin
                if (m_grant) state_next = READ;
            end
            READ: begin
                if (m_grant) begin
                    data_next  = m_din;
                    state_next = WRITE;
                end
            end
            WRITE: begin
                if (m_grant) begin
                    src_next   = src_reg + 8'd1;
                    dst_next   = dst_reg + 8'd1;
                    cnt_next   = cnt_reg - 8'd1;
                    state_next = (cnt_reg == 8'd1) ? DONE : READ;
                end
            end
            DONE: begin
                // Completion is held until software drops start; no retrigger.
                if (!rData[0]) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Moore output decode
    always_comb begin
        rAddr     = REG_OP;
        m_req     = 1'b0;
        m_wr      = 1'b0;
        m_addr    = 8'd0;
        m_dout    = 8'd0;
        busy      = 1'b0;
        op_done   = 1'b0;
        interrupt = 1'b0;
        case (state_reg)
            LOAD_CTRL: begin
                rAddr = REG_CTRL;
                busy  = 1'b1;
            end
            LOAD_SRC: begin
                rAddr = REG_SRC;
                busy  = 1'b1;
            end
            LOAD_DST: begin
                rAddr = REG_DST;
                busy  = 1'b1;
            end
            LOAD_SIZE: begin
                rAddr = REG_SIZE;
                busy  = 1'b1;
            end
            REQ: begin
                m_req = 1'b1;
                busy  = 1'b1;
            end
            READ: begin
                m_req  = 1'b1;
                m_addr = src_reg;
                busy   = 1'b1;
            end
            WRITE: begin
                m_req  = 1'b1;
                m_wr   = 1'b1;
                m_addr = dst_reg;
                m_dout = data_reg;
                busy   = 1'b1;
            end
            DONE: begin
                op_done   = 1'b1;
                interrupt = int_en_reg;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dmac_transfer_engine.sv
// Directed bench for dmac_transfer_engine: register-file and memory models,
// bus write logger and per-transfer latency/data/flag checks.
module tb_dmac_transfer_engine;

    logic       clk;
    logic       reset;
    logic [2:0] rAddr;
    logic [7:0] rData;
    logic       m_req;
    logic       m_grant;
    logic       m_wr;
    logic [7:0] m_addr;
    logic [7:0] m_dout;
    logic [7:0] m_din;
    logic       busy;
    logic       op_done;
    logic       interrupt;

    logic [7:0] regs [0:7];
    logic [7:0] wlog_addr [$];
    logic [7:0] wlog_data [$];
    logic       req_seen;
    int         checks;
    int         failures;

    dmac_transfer_engine dut (
        .clk       (clk),
        .reset     (reset),
        .rAddr     (rAddr),
        .rData     (rData),
        .m_req     (m_req),
        .m_grant   (m_grant),
        .m_wr      (m_wr),
        .m_addr    (m_addr),
        .m_dout    (m_dout),
        .m_din     (m_din),
        .busy      (busy),
        .op_done   (op_done),
        .interrupt (interrupt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Source memory contents are a fixed bijection of the address, so the
    // data written identifies which address was read.
    function automatic logic [7:0] mem_val(input logic [7:0] a);
        return a ^ 8'hA5;
    endfunction

    assign rData = regs[rAddr];
    assign m_din = mem_val(m_addr);

    always @(posedge clk) begin
        if (!reset && m_req && m_wr && m_grant) begin
            wlog_addr.push_back(m_addr);
            wlog_data.push_back(m_dout);
        end
    end

    always @(negedge clk) begin
        if (m_req) req_seen <= 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Programs the descriptor and raises start; the next rising edge is the
    // one at which IDLE samples start (cycle N).
    task automatic run_xfer(input logic [7:0] ctrl, input logic [7:0] src,
                            input logic [7:0] dst, input logic [7:0] size,
                            input bit stall, input bit rewrite, input int hold,
                            input string name);
        int         k;
        int         exp_lat;
        logic [7:0] sa;
        logic [7:0] sd;
        logic [7:0] ea;
        bit         stalled;
        regs[1] = ctrl;
        regs[2] = src;
        regs[3] = dst;
        regs[4] = size;
        regs[0] = 8'd1;
        wlog_addr.delete();
        wlog_data.delete();
        req_seen = 1'b0;
        exp_lat = (size == 8'd0) ? 4 : 5 + 2 * int'(size) + (stall ? 3 : 0);
        @(posedge clk); #1;
        k = 0;
        stalled = 1'b0;
        while (!op_done && k < 2000) begin
            @(posedge clk); #1;
            k++;
            if (rewrite && wlog_addr.size() > 0) regs[2] = 8'h55;
            if (stall && !stalled && m_wr) begin
                stalled = 1'b1;
                sa = m_addr;
                sd = m_dout;
                m_grant = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(posedge clk); #1;
                    k++;
                    check({name, "_stall_wr"}, 32'(m_wr), 32'd1);
                    check({name, "_stall_addr"}, 32'(m_addr), 32'(sa));
                    check({name, "_stall_dout"}, 32'(m_dout), 32'(sd));
                end
                m_grant = 1'b1;
            end
        end
        check({name, "_latency"}, 32'(k), 32'(exp_lat));
        check({name, "_op_done"}, 32'(op_done), 32'd1);
        check({name, "_interrupt"}, 32'(interrupt), 32'(ctrl[0]));
        check({name, "_busy_done"}, 32'(busy), 32'd0);
        check({name, "_nwrites"}, 32'(wlog_addr.size()), 32'(size));
        for (int i = 0; i < wlog_addr.size() && i < int'(size); i++) begin
            ea = dst + 8'(i);
            check({name, "_waddr"}, 32'(wlog_addr[i]), 32'(ea));
            ea = src + 8'(i);
            check({name, "_wdata"}, 32'(wlog_data[i]), 32'(mem_val(ea)));
        end
        if (size == 8'd0) check({name, "_no_req"}, 32'(req_seen), 32'd0);
        if (hold > 0) begin
            req_seen = 1'b0;
            repeat (hold) begin
                @(posedge clk); #1;
            end
            check({name, "_hold_done"}, 32'(op_done), 32'd1);
            check({name, "_hold_noreq"}, 32'(req_seen), 32'd0);
            check({name, "_hold_nwrites"}, 32'(wlog_addr.size()), 32'(size));
        end
        regs[0] = 8'd0;
        @(posedge clk); #1;
        check({name, "_clr_done"}, 32'(op_done), 32'd0);
        check({name, "_clr_int"}, 32'(interrupt), 32'd0);
        check({name, "_clr_busy"}, 32'(busy), 32'd0);
        $display("xfer %s src=%02h dst=%02h size=%0d cycles=%0d writes=%0d",
                 name, src, dst, size, k, wlog_addr.size());
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        m_grant  = 1'b1;
        req_seen = 1'b0;
        for (int i = 0; i < 8; i++) regs[i] = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rAddr", 32'(rAddr), 32'd0);
        check("rst_m_req", 32'(m_req), 32'd0);
        check("rst_m_wr", 32'(m_wr), 32'd0);
        check("rst_m_addr", 32'(m_addr), 32'd0);
        check("rst_m_dout", 32'(m_dout), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_op_done", 32'(op_done), 32'd0);
        check("rst_interrupt", 32'(interrupt), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        run_xfer(8'd1, 8'h10, 8'h80, 8'd3, 1'b0, 1'b0, 0, "basic");
        run_xfer(8'd0, 8'h30, 8'h90, 8'd0, 1'b0, 1'b0, 0, "zero");
        run_xfer(8'd1, 8'h40, 8'hA0, 8'd2, 1'b1, 1'b0, 0, "stall");
        run_xfer(8'd1, 8'hFE, 8'hFF, 8'd3, 1'b0, 1'b0, 0, "wrap");
        run_xfer(8'd0, 8'h05, 8'h50, 8'd4, 1'b0, 1'b1, 20, "latch");
        run_xfer(8'd1, 8'h55, 8'h70, 8'd2, 1'b0, 1'b0, 0, "restart");

        // Abort during the second READ of a 4-byte transfer.
        regs[1] = 8'd1;
        regs[2] = 8'h20;
        regs[3] = 8'h40;
        regs[4] = 8'd4;
        regs[0] = 8'd1;
        wlog_addr.delete();
        wlog_data.delete();
        @(posedge clk);
        repeat (7) @(posedge clk);
        #1;
        check("abort_pre_req", 32'(m_req), 32'd1);
        check("abort_pre_wr", 32'(m_wr), 32'd0);
        check("abort_pre_addr", 32'(m_addr), 32'h21);
        reset = 1'b1;
        #1;
        check("abort_m_req", 32'(m_req), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_m_addr", 32'(m_addr), 32'd0);
        check("abort_rAddr", 32'(rAddr), 32'd0);
        @(posedge clk); #1;
        check("abort_nwrites", 32'(wlog_addr.size()), 32'd1);
        check("abort_op_done", 32'(op_done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_xfer(8'd1, 8'h20, 8'h60, 8'd4, 1'b0, 1'b0, 0, "after_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
